// File: rtl/fetch_queue_if.sv
// Fetch-stage bundle: instruction-memory port, redirect request and decode handshake.
interface fetch_queue_if #(
    parameter int unsigned N      = 64,
    parameter int unsigned INSN_W = 32,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic              PCSrc_F;
    logic [N-1:0]      PCBranch_F;
    logic [N-1:0]      imem_addr_F;
    logic              imem_en_F;
    logic [INSN_W-1:0] imem_rdata_F;
    logic              valid_D;
    logic              ready_D;
    logic [INSN_W-1:0] instr_D;
    logic [N-1:0]      pc_D;
    logic [CW-1:0]     count_F;

    modport master (
        input  PCSrc_F, PCBranch_F, imem_rdata_F, ready_D,
        output imem_addr_F, imem_en_F, valid_D, instr_D, pc_D, count_F
    );

    modport slave (
        output PCSrc_F, PCBranch_F, imem_rdata_F, ready_D,
        input  imem_addr_F, imem_en_F, valid_D, instr_D, pc_D, count_F
    );
endinterface

// File: rtl/fetch_queue.sv
// Fetch stage: PC register, combinational imem read and a DEPTH-entry {pc, insn}
// FIFO toward decode; a redirect flushes every buffered wrong-path entry.
module fetch_queue #(
    parameter int unsigned   N        = 64,
    parameter int unsigned   INSN_W   = 32,
    parameter int unsigned   DEPTH    = 4,
    parameter int unsigned   STEP     = 4,
    parameter logic [N-1:0]  RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master fq
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [N-1:0]      pc;
        logic [INSN_W-1:0] insn;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [N-1:0]  pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic valid;
    logic full;
    logic pop;
    logic push;

    // Handshake decode; push is suppressed by reset and redirect.
    always_comb begin
        valid = (count != '0);
        full  = (count == CW'(DEPTH));
        pop   = valid & fq.ready_D;
        push  = ~reset & ~fq.PCSrc_F & (~full | pop);
    end

    // PC, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (fq.PCSrc_F) begin
            pc     <= fq.PCBranch_F;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                pc     <= pc + N'(STEP);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage carries no reset; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: pc, insn: fq.imem_rdata_F};
        end
    end

    assign fq.imem_addr_F = pc;
    assign fq.imem_en_F   = push;
    assign fq.valid_D     = valid;
    assign fq.pc_D        = mem[rd_ptr].pc;
    assign fq.instr_D     = mem[rd_ptr].insn;
    assign fq.count_F     = count;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a reference PC/queue model predicts every output and
// a scoreboard of fetched {pc, insn} pairs is checked as decode accepts entries.
module tb_fetch_queue;
    localparam int unsigned N      = 64;
    localparam int unsigned INSN_W = 32;
    localparam int unsigned DEPTH  = 4;

    typedef struct {
        logic [N-1:0]      pc;
        logic [INSN_W-1:0] insn;
    } exp_t;

    logic clk;
    logic reset;

    fetch_queue_if #(.N(N), .INSN_W(INSN_W), .DEPTH(DEPTH)) bus ();

    fetch_queue #(
        .N(N), .INSN_W(INSN_W), .DEPTH(DEPTH), .STEP(4), .RESET_PC('0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fq    (bus)
    );

    // Instruction memory: mem[a] = a >> 2.
    assign bus.imem_rdata_F = INSN_W'(bus.imem_addr_F >> 2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned  checks = 0;
    int unsigned  errors = 0;
    exp_t         sb[$];
    logic [N-1:0] m_pc;
    bit           m_known = 0;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check one cycle's outputs against the model, then advance model and clock.
    task automatic cycle();
        bit   m_pop;
        bit   m_push;
        exp_t e;
        #1;
        m_pop  = bus.ready_D && (sb.size() != 0);
        m_push = !reset && !bus.PCSrc_F && ((sb.size() < DEPTH) || m_pop);
        if (m_known) begin
            chk("imem_addr", bus.imem_addr_F, m_pc);
            chk("imem_en", N'(bus.imem_en_F), N'(m_push));
            chk("valid", N'(bus.valid_D), N'(sb.size() != 0));
            chk("count", N'(bus.count_F), N'(sb.size()));
            if (m_pop) begin
                chk("pc_D", bus.pc_D, sb[0].pc);
                chk("instr_D", N'(bus.instr_D), N'(sb[0].insn));
            end
        end
        if (reset) begin
            m_pc    = '0;
            sb.delete();
            m_known = 1;
        end else if (bus.PCSrc_F) begin
            m_pc = bus.PCBranch_F;
            sb.delete();
        end else begin
            if (m_pop) void'(sb.pop_front());
            if (m_push) begin
                e.pc   = m_pc;
                e.insn = INSN_W'(m_pc >> 2);
                sb.push_back(e);
                m_pc = m_pc + N'(4);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit rdy);
        bus.ready_D = rdy;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic redirect(input logic [N-1:0] tgt, input bit rdy);
        bus.PCSrc_F    = 1'b1;
        bus.PCBranch_F = tgt;
        bus.ready_D    = rdy;
        cycle();
        bus.PCSrc_F    = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        bus.PCSrc_F    = 1'b0;
        bus.PCBranch_F = '0;
        bus.ready_D    = 1'b1;

        // Reset twice: the second cycle checks imem_en low while reset is held.
        cycle();
        do_reset();

        // Streaming with decode always ready.
        run(8, 1'b1);

        // Backpressure fills the FIFO and freezes the PC, then drains in order.
        do_reset();
        run(10, 1'b0);
        run(8, 1'b1);

        // Full FIFO with a single pop.
        do_reset();
        run(5, 1'b0);
        run(1, 1'b1);
        run(2, 1'b0);

        // Redirect with three entries buffered, popping in the same cycle.
        do_reset();
        run(3, 1'b0);
        redirect(64'h100, 1'b1);
        run(4, 1'b1);

        // PC wraps modulo 2^N.
        redirect(64'hFFFF_FFFF_FFFF_FFF4, 1'b1);
        run(6, 1'b1);

        // Reset mid-stream with two entries buffered.
        do_reset();
        run(2, 1'b0);
        do_reset();
        run(3, 1'b1);

        // Randomised backpressure with occasional redirects.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                redirect(N'($urandom_range(0, 255)) << 2, 1'($urandom_range(0, 1)));
            end else begin
                run(1, 1'($urandom_range(0, 1)));
            end
        end
        run(6, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised fetch stage. It holds the program counter, reads instruction memory combinationally at the PC, and buffers {PC, instruction} pairs in a DEPTH-entry FIFO in front of decode. A valid/ready handshake toward decode replaces the free-running PC+4 loop, so decode backpressure stalls the PC. A branch redirect flushes all buffered wrong-path entries.

Parameters:
N, 64, address/PC width in bits
INSN_W, 32, instruction width in bits
DEPTH, 4, FIFO entries; power of two, >= 2
STEP, 4, PC increment per fetched instruction
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
PCSrc_F  in  1  redirect request; takes priority over everything except reset
PCBranch_F  in  N  redirect target PC
imem_addr_F  out  N  instruction memory address, equal to the current PC
imem_en_F  out  1  high when this cycle's read is enqueued
imem_rdata_F  in  INSN_W  instruction at imem_addr_F, combinational same-cycle
valid_D  out  1  FIFO head valid toward decode
ready_D  in  1  decode accepts the head this cycle
instr_D  out  INSN_W  instruction at FIFO head
pc_D  out  N  PC of the FIFO head instruction
count_F  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH

Behaviour:
- State: pc (N bits), FIFO storage of DEPTH x (N+INSN_W), rd_ptr/wr_ptr ($clog2(DEPTH) bits, wrap naturally), count.
- Reset (synchronous, sampled at edge): pc <= RESET_PC; rd_ptr, wr_ptr, count <= 0. After reset: imem_addr_F = RESET_PC, valid_D = 0, count_F = 0. FIFO data contents are don't-care.
- pop = valid_D & ready_D.
- full = (count == DEPTH).
- push = ~PCSrc_F & (~full | pop).
- imem_en_F = push. It is combinational, and imem_en_F = 0 during reset.
- Per-edge priority:
  1. reset
  2. PCSrc_F: pc <= PCBranch_F; count, rd_ptr, wr_ptr <= 0. This flushes all entries, including any being popped that cycle; the pop still counts as accepted by decode. Nothing is enqueued.
  3. otherwise: if push, write {pc, imem_rdata_F} at wr_ptr, advance wr_ptr, pc <= pc + STEP; if pop, advance rd_ptr. count += push - pop.
- PC arithmetic is modulo 2^N: 2^N - STEP + STEP wraps to 0. No overflow flag.
- PCBranch_F is loaded unmodified; no alignment check.
- Latency: an instruction read at PC X in cycle t appears at the head no earlier than cycle t+1. There is no memory-to-decode bypass. Redirect to target T in cycle t gives imem_addr_F = T in cycle t+1 and earliest valid_D with pc_D = T in cycle t+2.
- Full, no pop: PC holds, imem_en_F = 0, no entry lost or duplicated.
- Full with pop: push allowed, count stays DEPTH.
- Empty: valid_D = 0. ready_D is ignored and count never underflows.
- valid_D = (count != 0). instr_D/pc_D are read combinationally from rd_ptr and are stable while valid_D & ~ready_D.
- Throughput: one instruction per cycle sustained when ready_D is held high.

Test Plan:
- Reset, RESET_PC=0, ready_D=1, mem[a]=a>>2 -> imem_addr_F 0,4,8,...; valid_D first high the cycle after reset release with pc_D=0, instr_D=0; then pc_D increments by 4 every cycle.
- ready_D=0 for 10 cycles, DEPTH=4 -> count_F 1,2,3,4 then holds; imem_addr_F frozen at 16; imem_en_F=0; after ready_D=1, pc_D sequence 0,4,8,12,16 with no gap or duplicate.
- Full FIFO, ready_D=1 for one cycle -> count_F stays 4, pc advances by 4, popped pc_D=0.
- count_F=3, PCSrc_F=1, PCBranch_F=0x100 -> next cycle count_F=0, valid_D=0, imem_addr_F=0x100; following cycle valid_D=1, pc_D=0x100.
- pc=0xFFFF_FFFF_FFFF_FFFC, ready_D=1 -> next imem_addr_F=0; stream continues without error.
- Synchronous reset asserted mid-stream with count_F=2 -> next cycle count_F=0, valid_D=0, imem_addr_F=RESET_PC.
